// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Package     : button_pkg
// Description : Shared FSM state encoding and default timing constants for
//               the push-button conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_HOLD_CYCLES     = 50000000;
    localparam int DEF_REPEAT_CYCLES   = 10000000;

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : STAGES-deep flip-flop chain bringing an asynchronous pin into
//               the clk domain; asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff
    import button_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Synchronizes and debounces the raw push-button; produces a
//               clean level, press/release pulses and a press-toggled latch.
//               Define BUTTON_CONDITIONER_HOLD_EN for long-press hold/repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic CLK,
    input  logic CLR,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic release_pulse,   // "release" is a reserved word
    output logic toggle,
    output logic hold,
    output logic rpt
);

    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    generate
        if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
            $error("button_conditioner: illegal parameter value");
        end
    endgenerate

    logic               w_s_in;
    btn_state_e         r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic               r_level, w_level_nxt;
    logic               r_toggle, w_toggle_nxt;
    logic               r_press, w_press_nxt;
    logic               r_release, w_release_nxt;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (CLK),
        .rst (CLR),
        .i_d (btn_raw),
        .o_q (w_s_in)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_toggle  <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_toggle  <= w_toggle_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // The counter restarts on every entry to a WAIT state, so it can only
    // climb to DEBOUNCE_CYCLES-1 before the state is left.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_toggle_nxt  = r_toggle;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_s_in) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_s_in) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt  = PRESSED;
                    w_press_nxt  = 1'b1;
                    w_level_nxt  = 1'b1;
                    w_toggle_nxt = ~r_toggle;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            PRESSED: begin
                if (!w_s_in) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_s_in) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
                    w_level_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign level         = r_level;
    assign press         = r_press;
    assign release_pulse = r_release;
    assign toggle        = r_toggle;

`ifdef BUTTON_CONDITIONER_HOLD_EN
    localparam int                  c_hcnt_w    = $clog2(HOLD_CYCLES + 1);
    localparam int                  c_rcnt_w    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_hcnt_w-1:0] c_hold_last = c_hcnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_hcnt_w-1:0] c_hcnt_one  = c_hcnt_w'(1);
    localparam logic [c_rcnt_w-1:0] c_rpt_last  = c_rcnt_w'(REPEAT_CYCLES - 1);
    localparam logic [c_rcnt_w-1:0] c_rcnt_one  = c_rcnt_w'(1);

    logic [c_hcnt_w-1:0] r_hcnt;
    logic [c_rcnt_w-1:0] r_rcnt;
    logic                r_hold;
    logic                r_rpt;

    // Counters only advance in PRESSED, so a release bounce freezes them.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_hcnt <= '0;
            r_rcnt <= '0;
            r_hold <= 1'b0;
            r_rpt  <= 1'b0;
        end else begin
            r_rpt <= 1'b0;
            if (w_release_nxt) begin
                r_hcnt <= '0;
                r_rcnt <= '0;
                r_hold <= 1'b0;
            end else if (r_state == PRESSED) begin
                if (!r_hold) begin
                    if (r_hcnt == c_hold_last) begin
                        r_hold <= 1'b1;
                        r_rpt  <= 1'b1;
                        r_rcnt <= '0;
                    end else begin
                        r_hcnt <= r_hcnt + c_hcnt_one;
                    end
                end else if (r_rcnt == c_rpt_last) begin
                    r_rpt  <= 1'b1;
                    r_rcnt <= '0;
                end else begin
                    r_rcnt <= r_rcnt + c_rcnt_one;
                end
            end
        end
    end

    assign hold = r_hold;
    assign rpt  = r_rpt;
`else
    assign hold = 1'b0;
    assign rpt  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner, directed scenarios
//               plus random bouncing against a sample-history reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int HOLD_CYCLES     = 8;
    localparam int REPEAT_CYCLES   = 3;
`ifdef BUTTON_CONDITIONER_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic CLK     = 1'b0;
    logic CLR     = 1'b1;
    logic btn_raw = 1'b0;
    logic level, press, release_pulse, toggle, hold, rpt;
    int   n_total = 0;
    int   n_bad   = 0;

    button_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) dut (
        .CLK           (CLK),
        .CLR           (CLR),
        .btn_raw       (btn_raw),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .toggle        (toggle),
        .hold          (hold),
        .rpt           (rpt)
    );

    always #5 CLK = ~CLK;

    // Reference: the synchronized input is the raw pin delayed SYNC_STAGES
    // edges; the level flips once DEBOUNCE_CYCLES+1 consecutive samples
    // disagree with it. Hold time accumulates over edges spent pressed.
    typedef struct packed {
        logic [SYNC_STAGES-1:0] pipe;
        int                     run;
        logic                   prev_s;
        logic                   level, press, rel, toggle, hold, rpt;
        int                     hc;
        int                     rc;
    } mstate_t;

    function automatic mstate_t model_step(input mstate_t c, input logic raw);
        mstate_t n;
        logic    s;
        n        = c;
        s        = c.pipe[SYNC_STAGES-1];
        n.pipe   = {c.pipe[SYNC_STAGES-2:0], raw};
        n.press  = 1'b0;
        n.rel    = 1'b0;
        n.rpt    = 1'b0;
        n.run    = (s == c.prev_s) ? c.run + 1 : 1;
        n.prev_s = s;
        if (s != c.level && n.run >= DEBOUNCE_CYCLES + 1) begin
            n.level = s;
            if (s) begin
                n.press  = 1'b1;
                n.toggle = ~c.toggle;
            end else begin
                n.rel  = 1'b1;
                n.hold = 1'b0;
                n.hc   = 0;
                n.rc   = 0;
            end
        end else if (HOLD_EN && c.level && c.prev_s) begin
            if (!c.hold) begin
                n.hc = c.hc + 1;
                if (n.hc == HOLD_CYCLES) begin
                    n.hold = 1'b1;
                    n.rpt  = 1'b1;
                    n.rc   = 0;
                end
            end else begin
                n.rc = c.rc + 1;
                if (n.rc == REPEAT_CYCLES) begin
                    n.rpt = 1'b1;
                    n.rc  = 0;
                end
            end
        end
        return n;
    endfunction

    mstate_t m;
    always @(posedge CLK or posedge CLR) begin
        if (CLR) m <= '0;
        else     m <= model_step(m, btn_raw);
    end

    logic [5:0] dut_vec, exp_vec;
    assign dut_vec = {level, press, release_pulse, toggle, hold, rpt};
    assign exp_vec = {m.level, m.press, m.rel, m.toggle, m.hold, m.rpt};

    // Drive one input value across the next active edge; return at the
    // following falling edge where outputs are sampled.
    task automatic cyc(input logic b);
        btn_raw = b;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        btn_raw = 1'b0;
        CLR     = 1'b1;
        repeat (3) @(negedge CLK);
        n_total++;
        if (dut_vec !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b exp=%b", dut_vec, 6'b0);
        end
        CLR = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0);
            n_total++;
            if (dut_vec !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_idle k=%0d got=%b exp=%b", k, dut_vec, 6'b0);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [5:0] want;
        for (int k = 0; k < 12; k++) begin
            cyc(1'b1);
            want = {k >= 6, k == 6, 1'b0, k >= 6, 2'b00};
            n_total++;
            if (dut_vec !== want) begin
                n_bad++;
                $display("FAIL clean_press k=%0d got=%b exp=%b", k, dut_vec, want);
            end
        end
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0);
            n_total++;
            if (dut_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL clean_release k=%0d got=%b exp=%b", k, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_bounce();
        int presses = 0;
        int at      = -1;
        for (int k = 0; k < 16; k++) begin
            cyc((k < 3 || k >= 4) ? 1'b1 : 1'b0);
            if (press) begin
                presses++;
                at = k;
            end
            n_total++;
            if (dut_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL bounce_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec);
            end
        end
        n_total++;
        if (presses != 1 || at != 10) begin
            n_bad++;
            $display("FAIL bounce_press count=%0d at=%0d exp count=1 at=10", presses, at);
        end
        for (int k = 0; k < 10; k++) cyc(1'b0);
    endtask

    task automatic test_release_bounce();
        logic t0;
        int   pulses = 0;
        int   rels   = 0;
        for (int k = 0; k < 8; k++) cyc(1'b1);
        t0 = toggle;
        for (int k = 0; k < 12; k++) begin
            cyc(k < 2 ? 1'b0 : 1'b1);
            if (press || release_pulse) pulses++;
            n_total++;
            if (dut_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL rbounce_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec);
            end
        end
        n_total++;
        if (pulses != 0 || toggle !== t0 || level !== 1'b1) begin
            n_bad++;
            $display("FAIL rbounce_quiet pulses=%0d toggle=%b level=%b exp pulses=0 toggle=%b level=1",
                     pulses, toggle, level, t0);
        end
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0);
            if (release_pulse) rels++;
        end
        n_total++;
        if (rels != 1 || level !== 1'b0) begin
            n_bad++;
            $display("FAIL rbounce_release count=%0d level=%b exp count=1 level=0", rels, level);
        end
    endtask

    task automatic test_back_to_back();
        int         presses = 0;
        int         rels    = 0;
        int         both    = 0;
        logic [1:0] tog_after;
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        for (int k = 0; k < 3; k++) cyc(1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 16; k++) begin
                cyc(k < 8 ? 1'b1 : 1'b0);
                if (press) presses++;
                if (release_pulse) rels++;
                if (press && release_pulse) both++;
                n_total++;
                if (dut_vec !== exp_vec) begin
                    n_bad++;
                    $display("FAIL b2b_model r=%0d k=%0d got=%b exp=%b", r, k, dut_vec, exp_vec);
                end
                if (k == 7) tog_after[r] = toggle;
            end
        end
        n_total++;
        if (presses != 2 || rels != 2 || both != 0 || tog_after !== 2'b01 || toggle !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_summary press=%0d rel=%0d both=%0d tog=%b end=%b exp 2 2 0 tog=01 end=0",
                     presses, rels, both, tog_after, toggle);
        end
    endtask

    task automatic test_hold();
        logic exp_h, exp_r;
        for (int k = 0; k < 30; k++) begin
            cyc(1'b1);
            exp_h = HOLD_EN && (k >= 6 + HOLD_CYCLES);
            exp_r = exp_h && ((k - 6 - HOLD_CYCLES) % REPEAT_CYCLES == 0);
            n_total++;
            if ({hold, rpt} !== {exp_h, exp_r}) begin
                n_bad++;
                $display("FAIL hold_timing k=%0d got hold=%b rpt=%b exp hold=%b rpt=%b",
                         k, hold, rpt, exp_h, exp_r);
            end
        end
        for (int k = 0; k < 18; k++) begin
            cyc((k < 2 || k >= 8) ? 1'b0 : 1'b1);
            n_total++;
            if (dut_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL hold_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec);
            end
        end
        n_total++;
        if ({level, hold, rpt} !== 3'b000) begin
            n_bad++;
            $display("FAIL hold_cleared got level/hold/rpt=%b exp=000", {level, hold, rpt});
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] want;
        for (int k = 0; k < 3; k++) cyc(1'b1);
        CLR = 1'b1;
        #1;
        n_total++;
        if (dut_vec !== 6'b0) begin
            n_bad++;
            $display("FAIL midreset_async got=%b exp=%b", dut_vec, 6'b0);
        end
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1);
            n_total++;
            if (dut_vec !== 6'b0) begin
                n_bad++;
                $display("FAIL midreset_held k=%0d got=%b exp=%b", k, dut_vec, 6'b0);
            end
        end
        CLR = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1);
            want = {k >= 6, k == 6, 1'b0, k >= 6, 2'b00};
            n_total++;
            if (dut_vec !== want) begin
                n_bad++;
                $display("FAIL midreset_requal k=%0d got=%b exp=%b", k, dut_vec, want);
            end
        end
        for (int k = 0; k < 10; k++) cyc(1'b0);
    endtask

    task automatic test_random();
        int   left = 0;
        logic b    = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (left == 0) begin
                b    = 1'($urandom_range(0, 1));
                left = int'($urandom_range(1, 20));
            end
            left--;
            cyc(b);
            n_total++;
            if (dut_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL random_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec);
            end
        end
        for (int k = 0; k < 10; k++) cyc(1'b0);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
